// File: rtl/stream_fifo_module.sv
// stream_fifo_module
// Valid/ready stream buffer with first-word fall-through output, a choice of
// backpressure or drop-on-full behaviour, and occupancy / transfer / drop
// observability for regression benches.
module stream_fifo_module #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int DROP_MODE  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    input  logic [DATA_WIDTH-1:0]   stream_in_data,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic [DATA_WIDTH-1:0]   stream_out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    transfer_count,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    overflow_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]     FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [CNT_WIDTH-1:0]  transferCount_q, transferCount_d;
    logic [CNT_WIDTH-1:0]  dropCount_q, dropCount_d;
    logic                  overflow_q, overflow_d;
    logic                  full;
    logic                  pop;
    logic                  write;
    logic                  drop;

    // Ready only depends on occupancy (never on stream_out_ready) and is held low during reset.
    assign stream_in_ready  = reset_n & ((DROP_MODE != 0) | ~full);
    assign stream_out_valid = (level_q != '0);
    assign stream_out_data  = mem_q[rdPtr_q];
    assign level            = level_q;
    assign transfer_count   = transferCount_q;
    assign drop_count       = dropCount_q;
    assign overflow_seen    = overflow_q;

    // Handshake decode and next-state computation for pointers, level and counters.
    always_comb begin
        full            = (level_q == FULL_LEVEL);
        pop             = stream_out_valid & stream_out_ready;
        write           = 1'b0;
        drop            = 1'b0;
        wrPtr_d         = wrPtr_q;
        rdPtr_d         = rdPtr_q;
        level_d         = level_q;
        transferCount_d = transferCount_q;
        dropCount_d     = dropCount_q;
        overflow_d      = overflow_q;

        if (DROP_MODE != 0) begin
            write = stream_in_valid & (~full | pop);
            drop  = stream_in_valid & ~write;
        end else begin
            write = stream_in_valid & ~full;
        end

        if (write) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d         = rdPtr_q + PTR_W'(1);
            transferCount_d = transferCount_q + CNT_WIDTH'(1);
        end

        case ({write, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (dropCount_q != CNT_MAX) begin
                dropCount_d = dropCount_q + CNT_WIDTH'(1);
            end
        end
    end

    // Control state register; reset throws away every buffered beat and all counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            level_q         <= '0;
            transferCount_q <= '0;
            dropCount_q     <= '0;
            overflow_q      <= 1'b0;
        end else begin
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            level_q         <= level_d;
            transferCount_q <= transferCount_d;
            dropCount_q     <= dropCount_d;
            overflow_q      <= overflow_d;
        end
    end

    // Payload storage, cleared on reset so the output reads zero until the first write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write) begin
            mem_q[wrPtr_q] <= stream_in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo_module.sv
// tb_stream_fifo_module
// Drives three configurations of the stream FIFO (backpressure depth 4,
// drop-on-full depth 4, wide backpressure depth 8) and compares them against
// a queue-based reference model.
module tb_stream_fifo_module;

    logic clk = 1'b0;
    logic reset_n;
    logic inV  [3];
    logic outR [3];
    logic [7:0]  d0In, d1In;
    logic [38:0] d2In;

    wire        o0V, i0R, ov0, o1V, i1R, ov1, o2V, i2R, ov2;
    wire [7:0]  o0D, o1D;
    wire [38:0] o2D;
    wire [2:0]  l0, l1;
    wire [3:0]  l2;
    wire [15:0] t0, c0, t1, c1, t2, c2;

    int checks = 0;
    int passes = 0;

    // Reference model: one queue of payloads per instance plus counter images.
    logic [63:0] mq [3][$];
    int          mTc [3];
    int          mDc [3];
    bit          mOv [3];

    always #5 clk = ~clk;

    stream_fifo_module #(.DATA_WIDTH(8), .DEPTH(4), .DROP_MODE(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .stream_in_valid(inV[0]), .stream_in_ready(i0R), .stream_in_data(d0In),
        .stream_out_valid(o0V), .stream_out_ready(outR[0]), .stream_out_data(o0D),
        .level(l0), .transfer_count(t0), .drop_count(c0), .overflow_seen(ov0));

    stream_fifo_module #(.DATA_WIDTH(8), .DEPTH(4), .DROP_MODE(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .stream_in_valid(inV[1]), .stream_in_ready(i1R), .stream_in_data(d1In),
        .stream_out_valid(o1V), .stream_out_ready(outR[1]), .stream_out_data(o1D),
        .level(l1), .transfer_count(t1), .drop_count(c1), .overflow_seen(ov1));

    stream_fifo_module #(.DATA_WIDTH(39), .DEPTH(8), .DROP_MODE(0), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .stream_in_valid(inV[2]), .stream_in_ready(i2R), .stream_in_data(d2In),
        .stream_out_valid(o2V), .stream_out_ready(outR[2]), .stream_out_data(o2D),
        .level(l2), .transfer_count(t2), .drop_count(c2), .overflow_seen(ov2));

    function automatic int depthOf(int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic int modeOf(int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic logic gV(int d);
        case (d) 0: return o0V; 1: return o1V; default: return o2V; endcase
    endfunction

    function automatic logic gR(int d);
        case (d) 0: return i0R; 1: return i1R; default: return i2R; endcase
    endfunction

    function automatic logic gO(int d);
        case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction

    function automatic logic [63:0] gD(int d);
        case (d) 0: return {56'b0, o0D}; 1: return {56'b0, o1D}; default: return {25'b0, o2D}; endcase
    endfunction

    function automatic logic [3:0] gL(int d);
        case (d) 0: return {1'b0, l0}; 1: return {1'b0, l1}; default: return l2; endcase
    endfunction

    function automatic logic [15:0] gT(int d);
        case (d) 0: return t0; 1: return t1; default: return t2; endcase
    endfunction

    function automatic logic [15:0] gC(int d);
        case (d) 0: return c0; 1: return c1; default: return c2; endcase
    endfunction

    function automatic logic [63:0] curData(int d);
        case (d) 0: return {56'b0, d0In}; 1: return {56'b0, d1In}; default: return {25'b0, d2In}; endcase
    endfunction

    function automatic logic expReady(int d);
        return (modeOf(d) == 1) || (mq[d].size() != depthOf(d));
    endfunction

    task automatic setData(int d, logic [63:0] v);
        case (d)
            0:       d0In = v[7:0];
            1:       d1In = v[7:0];
            default: d2In = v[38:0];
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model update: pop the head if shown and taken, then admit or drop the offer.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 3; d++) begin
                mq[d].delete();
                mTc[d] = 0;
                mDc[d] = 0;
                mOv[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                bit popNow;
                bit fullNow;
                bit admit;
                popNow  = (mq[d].size() > 0) && (outR[d] === 1'b1);
                fullNow = (mq[d].size() == depthOf(d));
                admit   = (inV[d] === 1'b1) && (!fullNow || (modeOf(d) == 1 && popNow));
                if (popNow) begin
                    void'(mq[d].pop_front());
                    mTc[d] = (mTc[d] + 1) % 65536;
                end
                if (admit) begin
                    mq[d].push_back(curData(d));
                end else if ((inV[d] === 1'b1) && modeOf(d) == 1) begin
                    if (mDc[d] < 65535) mDc[d] = mDc[d] + 1;
                    mOv[d] = 1'b1;
                end
            end
        end
    end

    // Reset clears every output; ready rises as soon as reset is released.
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (gV(d) !== 1'b0) $display("[TB] FAIL reset_valid dut%0d: got %0h expected 0", d, gV(d)); else passes++;
            checks++; if (gR(d) !== 1'b0) $display("[TB] FAIL reset_ready dut%0d: got %0h expected 0", d, gR(d)); else passes++;
            checks++; if (gD(d) !== 64'h0) $display("[TB] FAIL reset_data dut%0d: got %0h expected 0", d, gD(d)); else passes++;
            checks++; if (gL(d) !== 4'h0) $display("[TB] FAIL reset_level dut%0d: got %0h expected 0", d, gL(d)); else passes++;
            checks++; if ({gT(d), gC(d), gO(d)} !== 33'h0) $display("[TB] FAIL reset_counters dut%0d: got %0h expected 0", d, {gT(d), gC(d), gO(d)}); else passes++;
        end
        #2 reset_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (gR(d) !== 1'b1) $display("[TB] FAIL release_ready dut%0d: got %0h expected 1", d, gR(d)); else passes++;
        end
        @(negedge clk);
    endtask

    // Three beats pushed back-to-back stream out on consecutive cycles, one cycle later.
    task automatic test_back_to_back();
        logic [7:0] vals [3];
        logic [63:0] hd;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        outR[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inV[0] = (i < 3);
            d0In   = (i < 3) ? vals[i] : 8'h00;
            tick();
            if (i < 3) begin
                hd = gD(0);
                checks++; if (gV(0) !== 1'b1) $display("[TB] FAIL b2b_valid beat%0d: got %0h expected 1", i, gV(0)); else passes++;
                checks++; if (hd[7:0] !== vals[i]) $display("[TB] FAIL b2b_data beat%0d: got %0h expected %0h", i, hd[7:0], vals[i]); else passes++;
            end
        end
        inV[0] = 1'b0;
        outR[0] = 1'b0;
        checks++; if (gV(0) !== 1'b0) $display("[TB] FAIL b2b_empty: got %0h expected 0", gV(0)); else passes++;
        checks++; if (gT(0) !== 16'd3) $display("[TB] FAIL b2b_transfers: got %0d expected 3", gT(0)); else passes++;
    endtask

    // Backpressure: after four accepts ready drops and the remaining beats wait, not lost.
    task automatic test_backpressure();
        logic [7:0]  beats [6];
        logic [7:0]  got [$];
        logic [63:0] hd;
        int idx = 0;
        int budget = 0;
        bit willAcc;
        for (int i = 0; i < 6; i++) beats[i] = 8'($urandom);
        outR[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            inV[0] = 1'b1;
            d0In   = beats[idx];
            checks++; if (gR(0) !== expReady(0)) $display("[TB] FAIL bp_ready cycle%0d: got %0h expected %0h", c, gR(0), expReady(0)); else passes++;
            willAcc = (gR(0) === 1'b1);
            tick();
            if (willAcc && idx < 5) idx++;
        end
        checks++; if (idx !== 4) $display("[TB] FAIL bp_accepts: got %0d expected 4", idx); else passes++;
        checks++; if (gL(0) !== 4'd4) $display("[TB] FAIL bp_level: got %0d expected 4", gL(0)); else passes++;
        checks++; if (gR(0) !== 1'b0) $display("[TB] FAIL bp_ready_full: got %0h expected 0", gR(0)); else passes++;
        outR[0] = 1'b1;
        while (got.size() < 6 && budget < 40) begin
            inV[0]  = (idx < 6);
            d0In    = (idx < 6) ? beats[idx] : 8'h00;
            willAcc = (inV[0] === 1'b1) && (gR(0) === 1'b1);
            if (gV(0) === 1'b1) begin
                hd = gD(0);
                got.push_back(hd[7:0]);
            end
            tick();
            if (willAcc) idx++;
            budget++;
        end
        inV[0] = 1'b0;
        outR[0] = 1'b0;
        checks++; if (got.size() != 6) $display("[TB] FAIL bp_drain_count: got %0d expected 6", got.size()); else passes++;
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++; if (got[i] !== beats[i]) $display("[TB] FAIL bp_order beat%0d: got %0h expected %0h", i, got[i], beats[i]); else passes++;
        end
    endtask

    // Drop mode: beats offered into a full buffer are discarded and counted.
    task automatic test_drop();
        logic [63:0] hd;
        outR[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inV[1] = 1'b1;
            d1In   = 8'hA0 + 8'(i);
            checks++; if (gR(1) !== 1'b1) $display("[TB] FAIL drop_ready beat%0d: got %0h expected 1", i, gR(1)); else passes++;
            tick();
        end
        inV[1] = 1'b0;
        checks++; if (gL(1) !== 4'd4) $display("[TB] FAIL drop_level: got %0d expected 4", gL(1)); else passes++;
        checks++; if (gC(1) !== 16'd2) $display("[TB] FAIL drop_count: got %0d expected 2", gC(1)); else passes++;
        checks++; if (gO(1) !== 1'b1) $display("[TB] FAIL drop_overflow: got %0h expected 1", gO(1)); else passes++;
        outR[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hd = gD(1);
            checks++; if (gV(1) !== 1'b1) $display("[TB] FAIL drop_drain_valid beat%0d: got %0h expected 1", i, gV(1)); else passes++;
            checks++; if (hd[7:0] !== 8'hA0 + 8'(i)) $display("[TB] FAIL drop_drain_data beat%0d: got %0h expected %0h", i, hd[7:0], 8'hA0 + 8'(i)); else passes++;
            tick();
        end
        outR[1] = 1'b0;
        checks++; if (gV(1) !== 1'b0) $display("[TB] FAIL drop_drained: got %0h expected 0", gV(1)); else passes++;
        checks++; if (gT(1) !== 16'(mTc[1])) $display("[TB] FAIL drop_transfers: got %0d expected %0d", gT(1), mTc[1]); else passes++;
    endtask

    // Full buffer with a same-cycle offer and pop, in both modes.
    task automatic test_full_swap();
        for (int d = 0; d < 2; d++) begin
            logic [7:0]  fill [4];
            logic [7:0]  got [$];
            logic [63:0] hd;
            int budget;
            bit pending;
            bit willAcc;
            outR[d] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                fill[i] = 8'($urandom);
                inV[d]  = 1'b1;
                setData(d, {56'b0, fill[i]});
                tick();
            end
            inV[d] = 1'b0;
            checks++; if (gL(d) !== 4'd4) $display("[TB] FAIL swap_fill_level dut%0d: got %0d expected 4", d, gL(d)); else passes++;
            inV[d]  = 1'b1;
            setData(d, 64'h5A);
            outR[d] = 1'b1;
            pending = 1'b1;
            budget  = 0;
            while ((pending || got.size() < 5) && budget < 20) begin
                willAcc = (inV[d] === 1'b1) && (gR(d) === 1'b1);
                if (gV(d) === 1'b1) begin
                    hd = gD(d);
                    got.push_back(hd[7:0]);
                end
                tick();
                budget++;
                if (willAcc) begin
                    pending = 1'b0;
                    inV[d]  = 1'b0;
                end
                if (budget == 1) begin
                    checks++; if (gL(d) !== ((d == 1) ? 4'd4 : 4'd3)) $display("[TB] FAIL swap_level dut%0d: got %0d expected %0d", d, gL(d), (d == 1) ? 4 : 3); else passes++;
                    checks++; if (gC(d) !== ((d == 1) ? 16'd2 : 16'd0)) $display("[TB] FAIL swap_drops dut%0d: got %0d expected %0d", d, gC(d), (d == 1) ? 2 : 0); else passes++;
                end
            end
            inV[d]  = 1'b0;
            outR[d] = 1'b0;
            checks++; if (got.size() != 5) $display("[TB] FAIL swap_count dut%0d: got %0d expected 5", d, got.size()); else passes++;
            for (int i = 0; i < got.size() && i < 5; i++) begin
                hd = (i < 4) ? {56'b0, fill[i]} : 64'h5A;
                checks++; if (got[i] !== hd[7:0]) $display("[TB] FAIL swap_order dut%0d beat%0d: got %0h expected %0h", d, i, got[i], hd[7:0]); else passes++;
            end
        end
    endtask

    // Wide, deep instance with random traffic: exact order across pointer wrap.
    task automatic test_wrap_random();
        logic [38:0] beats [20];
        logic [38:0] got [$];
        logic [63:0] hd;
        int idx = 0;
        int budget = 0;
        bit willAcc;
        for (int i = 0; i < 20; i++) beats[i] = {7'($urandom), 32'($urandom)};
        while (got.size() < 20 && budget < 400) begin
            inV[2]  = (idx < 20) && ($urandom_range(0, 3) != 0);
            d2In    = (idx < 20) ? beats[idx] : 39'h0;
            outR[2] = ($urandom_range(0, 1) == 1);
            checks++; if (gL(2) !== 4'(mq[2].size()) || gL(2) > 4'd8) $display("[TB] FAIL wrap_level cycle%0d: got %0d expected %0d", budget, gL(2), mq[2].size()); else passes++;
            willAcc = (inV[2] === 1'b1) && (gR(2) === 1'b1);
            if (gV(2) === 1'b1 && outR[2] === 1'b1) begin
                hd = gD(2);
                got.push_back(hd[38:0]);
            end
            tick();
            if (willAcc) idx++;
            budget++;
        end
        inV[2]  = 1'b0;
        outR[2] = 1'b0;
        checks++; if (got.size() != 20) $display("[TB] FAIL wrap_count: got %0d expected 20", got.size()); else passes++;
        for (int i = 0; i < got.size() && i < 20; i++) begin
            checks++; if (got[i] !== beats[i]) $display("[TB] FAIL wrap_order beat%0d: got %0h expected %0h", i, got[i], beats[i]); else passes++;
        end
        checks++; if (gT(2) !== 16'd20) $display("[TB] FAIL wrap_transfers: got %0d expected 20", gT(2)); else passes++;
    endtask

    // Reset asserted between clock edges with three beats buffered.
    task automatic test_async_reset();
        logic [63:0] hd;
        outR[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inV[0] = 1'b1;
            d0In   = 8'h40 + 8'(i);
            tick();
        end
        inV[0] = 1'b0;
        checks++; if (gL(0) !== 4'd3) $display("[TB] FAIL areset_pre_level: got %0d expected 3", gL(0)); else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (gV(0) !== 1'b0) $display("[TB] FAIL areset_valid: got %0h expected 0", gV(0)); else passes++;
        checks++; if (gL(0) !== 4'd0) $display("[TB] FAIL areset_level: got %0d expected 0", gL(0)); else passes++;
        checks++; if (gT(0) !== 16'd0) $display("[TB] FAIL areset_transfers: got %0d expected 0", gT(0)); else passes++;
        checks++; if (gD(0) !== 64'h0) $display("[TB] FAIL areset_data: got %0h expected 0", gD(0)); else passes++;
        checks++; if ({gC(1), gO(1)} !== 17'h0) $display("[TB] FAIL areset_drop_state: got %0h expected 0", {gC(1), gO(1)}); else passes++;
        checks++; if (gR(0) !== 1'b0) $display("[TB] FAIL areset_ready: got %0h expected 0", gR(0)); else passes++;
        #1 reset_n = 1'b1;
        @(negedge clk);
        inV[0] = 1'b1;
        d0In   = 8'h77;
        tick();
        inV[0] = 1'b0;
        hd = gD(0);
        checks++; if (gV(0) !== 1'b1) $display("[TB] FAIL areset_first_valid: got %0h expected 1", gV(0)); else passes++;
        checks++; if (hd[7:0] !== 8'h77) $display("[TB] FAIL areset_first_data: got %0h expected 77", hd[7:0]); else passes++;
        checks++; if (gL(0) !== 4'd1) $display("[TB] FAIL areset_first_level: got %0d expected 1", gL(0)); else passes++;
    endtask

    // Test sequence.
    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            inV[d]  = 1'b0;
            outR[d] = 1'b0;
        end
        d0In = '0;
        d1In = '0;
        d2In = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_full_swap();
        test_wrap_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
